// File: rtl/ce_sched.sv
// ce_sched: issues NUM_OC filter operations per input window to the convolution engine,
// holding issue back so every in-flight result is guaranteed a slot in the result FIFO.
module ce_sched #(
    parameter int  NUM_OC = 4,
    parameter int  LAT    = 4,
    parameter int  DW     = 31,
    parameter int  FIFO_D = 8,
    localparam int OCW    = (NUM_OC > 1) ? $clog2(NUM_OC) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [15:0]    cfg_num_win,
    input  logic           win_valid,
    output logic           win_ready,
    output logic           ce_en_in,
    output logic [OCW-1:0] w_sel,
    input  logic           ce_en_out,
    input  logic [DW-1:0]  ce_d_out,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [DW-1:0]  res_data,
    output logic [OCW-1:0] res_oc,
    output logic           res_last,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [1:0]     dbg_state_o
);

    if (NUM_OC < 1 || NUM_OC > 256) begin : g_bad_num_oc
        $error("ce_sched: NUM_OC must be 1..256");
    end
    if (LAT < 1 || LAT > 16) begin : g_bad_lat
        $error("ce_sched: LAT must be 1..16");
    end
    if (FIFO_D < 2 || (FIFO_D & (FIFO_D - 1)) != 0) begin : g_bad_fifo_d
        $error("ce_sched: FIFO_D must be a power of 2, >= 2");
    end

    localparam int CW = $clog2(FIFO_D + 1);
    localparam int PW = $clog2(FIFO_D);
    localparam logic [OCW-1:0] OC_LAST    = OCW'(NUM_OC - 1);
    localparam logic [CW-1:0]  FIFO_FULLC = CW'(FIFO_D);
    localparam logic [CW:0]    CREDIT     = (CW + 1)'(FIFO_D);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e         state_q;
    logic [15:0]    num_win_q, win_cnt_q, res_win_q;
    logic [OCW-1:0] oc_cnt_q, res_oc_q;
    logic [CW-1:0]  infl_q, infl_d, fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DW-1:0]  mem_q [FIFO_D];
    logic           err_q;

    logic issue, oc_wrap, win_hs, last_win, run_active;
    logic fifo_empty, fifo_full, pop, push, infl_dec, ret_bad, res_last_c, last_pop;

    // Handshakes: a transfer happens in any cycle where valid && ready are both high at the
    // clock edge. win_ready only rises on the last filter of a window, so the producer keeps
    // the window stable across its NUM_OC issue cycles; res_data is held while res_ready is low.
    assign issue      = (state_q == S_RUN) && win_valid &&
                        (({1'b0, infl_q} + {1'b0, fifo_cnt_q}) < CREDIT);
    assign oc_wrap    = (oc_cnt_q == OC_LAST);
    assign win_hs     = issue && oc_wrap;
    assign last_win   = ((win_cnt_q + 16'd1) == num_win_q);
    assign run_active = (state_q == S_RUN) || (state_q == S_DRAIN);

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == FIFO_FULLC);
    assign pop        = !fifo_empty && res_ready;
    assign infl_dec   = ce_en_out && (infl_q != '0);
    // A return with nothing outstanding, or one that finds the FIFO full, is dropped.
    assign ret_bad    = ce_en_out && ((infl_q == '0) || (fifo_full && !pop));
    assign push       = ce_en_out && !ret_bad;

    assign res_last_c = !fifo_empty && run_active &&
                        (res_win_q == num_win_q - 16'd1) && (res_oc_q == OC_LAST);
    assign last_pop   = pop && res_last_c;

    always_comb begin
        infl_d = infl_q;
        if (issue && !infl_dec) begin
            infl_d = infl_q + 1'b1;
        end else if (!issue && infl_dec) begin
            infl_d = infl_q - 1'b1;
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) begin
            fifo_cnt_d = fifo_cnt_q + 1'b1;
        end else if (!push && pop) begin
            fifo_cnt_d = fifo_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            num_win_q <= '0;
            win_cnt_q <= '0;
            oc_cnt_q  <= '0;
            res_oc_q  <= '0;
            res_win_q <= '0;
        end else begin
            if (issue) begin
                oc_cnt_q <= oc_wrap ? '0 : oc_cnt_q + 1'b1;
            end
            if (win_hs) begin
                win_cnt_q <= win_cnt_q + 16'd1;
            end
            if (pop) begin
                res_oc_q <= (res_oc_q == OC_LAST) ? '0 : res_oc_q + 1'b1;
                if (res_oc_q == OC_LAST) begin
                    res_win_q <= res_win_q + 16'd1;
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_win_q <= cfg_num_win;
                        win_cnt_q <= '0;
                        oc_cnt_q  <= '0;
                        res_oc_q  <= '0;
                        res_win_q <= '0;
                        state_q   <= (cfg_num_win == 16'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN:   if (win_hs && last_win) state_q <= S_DRAIN;
                S_DRAIN: if (last_pop) state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infl_q     <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            infl_q     <= infl_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (ret_bad) err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ce_d_out;
        end
    end

    assign ce_en_in    = issue;
    assign w_sel       = oc_cnt_q;
    assign win_ready   = win_hs;
    assign res_valid   = !fifo_empty;
    assign res_data    = mem_q[rd_ptr_q];
    assign res_oc      = res_oc_q;
    assign res_last    = res_last_c;
    assign busy        = run_active;
    assign done        = (state_q == S_DONE);
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ce_sched.sv
// Bench for ce_sched: a latency-LAT CE model feeds results back, and a per-cycle compare
// process predicts issue, window handshake, result stream, busy/done and err from counts.
module tb_ce_sched;

    localparam int NUM_OC = 4;
    localparam int LAT    = 4;
    localparam int DW     = 31;
    localparam int FIFO_D = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   cfg_num_win = 16'd0;
    logic          win_valid = 1'b0;
    logic          res_ready = 1'b0;
    logic          inj = 1'b0;
    logic          win_ready, ce_en_in, ce_en_out;
    logic [1:0]    w_sel, res_oc, dbg_state;
    logic [DW-1:0] ce_d_out, res_data;
    logic          res_valid, res_last, busy, done, err;

    ce_sched #(.NUM_OC(NUM_OC), .LAT(LAT), .DW(DW), .FIFO_D(FIFO_D)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_num_win(cfg_num_win),
        .win_valid(win_valid), .win_ready(win_ready),
        .ce_en_in(ce_en_in), .w_sel(w_sel),
        .ce_en_out(ce_en_out), .ce_d_out(ce_d_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_oc(res_oc), .res_last(res_last),
        .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    int iss_k = 0, pop_p = 0, ret_k = 0, total = 0, g_iss = 0;
    bit run_active = 1'b0, done_exp = 1'b0, err_exp = 1'b0;
    int issue_cyc[64], pop_cyc[64], wsel_log[64];
    int done_cyc = 0, done_cnt = 0, last_cnt = 0, last_idx = -1, start_cyc = 0;

    function automatic logic [DW-1:0] ce_data(input int unsigned tag, input int unsigned oc);
        logic [31:0] v;
        v = tag * 32'd40503 + oc * 32'd977 + 32'h5a5;
        return v[DW-1:0];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- CE model: fixed LAT pipeline, shares rst ----------------
    logic [LAT-1:0] pipe_v = '0;
    logic [DW-1:0]  pipe_d [LAT];
    int unsigned    ce_tag = 0;

    always @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v    <= {pipe_v[LAT-2:0], ce_en_in};
            pipe_d[0] <= ce_data(ce_tag, 32'(w_sel));
            for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
            if (ce_en_in) ce_tag <= ce_tag + 1;
        end
    end

    assign ce_en_out = pipe_v[LAT-1] | inj;
    assign ce_d_out  = pipe_d[LAT-1];

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        bit exp_issue;
        logic [DW-1:0] e;
        if (!rst) begin
            chk("busy", 64'(busy), 64'(run_active));
            chk("done", 64'(done), 64'(done_exp));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            done_exp = 1'b0;
            chk("err", 64'(err), 64'(err_exp));
            chk("res_valid", 64'(res_valid), 64'(ret_k > pop_p));
            exp_issue = run_active && win_valid && (iss_k < total) && ((iss_k - pop_p) < FIFO_D);
            chk("ce_en_in", 64'(ce_en_in), 64'(exp_issue));
            chk("win_ready", 64'(win_ready), 64'(exp_issue && ((iss_k % NUM_OC) == NUM_OC - 1)));
            if (ce_en_in) chk("w_sel", 64'(w_sel), 64'(iss_k % NUM_OC));
            if (res_valid && res_ready) begin
                e = '0;
                if (exp_q.size() > 0) e = exp_q.pop_front();
                chk("res_data", 64'(res_data), 64'(e));
                chk("res_oc", 64'(res_oc), 64'(pop_p % NUM_OC));
                chk("res_last", 64'(res_last), 64'(pop_p == total - 1));
                if (res_last) begin
                    last_cnt++;
                    last_idx = pop_p;
                end
                if (pop_p < 64) pop_cyc[pop_p] = cyc;
                pop_p++;
                if (run_active && pop_p == total) begin
                    run_active = 1'b0;
                    done_exp   = 1'b1;
                end
            end
            if (ce_en_out) begin
                if (ret_k < iss_k) ret_k++;
                else err_exp = 1'b1;
            end
            if (ce_en_in) begin
                exp_q.push_back(ce_data(g_iss, iss_k % NUM_OC));
                if (iss_k < 64) begin
                    issue_cyc[iss_k] = cyc;
                    wsel_log[iss_k]  = int'(w_sel);
                end
                iss_k++;
            end
        end
        if (!rst && ce_en_in) g_iss++;
    end

    // ---------------- driver tasks ----------------
    task automatic run(input int n);
        @(posedge clk); #1;
        start       = 1'b1;
        cfg_num_win = 16'(n);
        start_cyc   = cyc;
        @(posedge clk); #1;
        start      = 1'b0;
        iss_k      = 0;
        pop_p      = 0;
        ret_k      = 0;
        exp_q.delete();
        total      = n * NUM_OC;
        run_active = (n != 0);
        done_exp   = (n == 0);
        last_cnt   = 0;
        last_idx   = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst        = 1'b0;
        iss_k      = 0;
        pop_p      = 0;
        ret_k      = 0;
        total      = 0;
        exp_q.delete();
        run_active = 1'b0;
        done_exp   = 1'b0;
        err_exp    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int snap;
        bit seen;
        snap = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            if (done_cnt != snap) begin
                seen = 1'b1;
                break;
            end
        end
        #1;
        chk({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ce_en_in"},  64'(ce_en_in),  64'd0);
        chk({name, "_win_ready"}, 64'(win_ready), 64'd0);
        chk({name, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({name, "_res_last"},  64'(res_last),  64'd0);
        chk({name, "_busy"},      64'(busy),      64'd0);
        chk({name, "_done"},      64'(done),      64'd0);
        chk({name, "_err"},       64'(err),       64'd0);
        chk({name, "_state"},     64'(dbg_state), 64'd0);
    endtask

    // ---------------- directed stimulus ----------------
    int t1_wsel[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int snap;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_idle_outputs("rst");

        // Two windows, fully unthrottled.
        win_valid = 1'b1;
        res_ready = 1'b1;
        run(2);
        wait_done("t1");
        chk("t1_issues", 64'(iss_k), 64'd8);
        chk("t1_pops", 64'(pop_p), 64'd8);
        chk("t1_first_issue", 64'(issue_cyc[0] - start_cyc), 64'd1);
        chk("t1_back_to_back", 64'(issue_cyc[7] - issue_cyc[0]), 64'd7);
        for (int i = 0; i < 8; i++) chk("t1_wsel", 64'(wsel_log[i]), 64'(t1_wsel[i]));
        chk("t1_first_result", 64'(pop_cyc[0] - issue_cyc[0]), 64'd5);
        chk("t1_last_cnt", 64'(last_cnt), 64'd1);
        chk("t1_last_idx", 64'(last_idx), 64'd7);
        chk("t1_done_gap", 64'(done_cyc - pop_cyc[7]), 64'd1);

        // Output stalled: issue must stop at FIFO_D credits.
        res_ready = 1'b0;
        run(4);
        repeat (30) @(posedge clk);
        #1;
        chk("t2_issues_stalled", 64'(iss_k), 64'd8);
        chk("t2_res_valid", 64'(res_valid), 64'd1);
        chk("t2_err", 64'(err), 64'd0);
        chk("t2_ce_en_in", 64'(ce_en_in), 64'd0);
        res_ready = 1'b1;
        wait_done("t2");
        chk("t2_resume", 64'(issue_cyc[8] - pop_cyc[0]), 64'd1);
        chk("t2_issues_total", 64'(iss_k), 64'd16);

        // win_valid alternating every cycle.
        win_valid = 1'b0;
        run(3);
        snap = done_cnt;
        for (int i = 0; i < 300 && done_cnt == snap; i++) begin
            win_valid = ~win_valid;
            @(posedge clk); #1;
        end
        chk("t3_done_seen", 64'(done_cnt != snap), 64'd1);
        chk("t3_issues", 64'(iss_k), 64'd12);
        chk("t3_gap", 64'(issue_cyc[1] - issue_cyc[0]), 64'd2);
        chk("t3_span", 64'(issue_cyc[11] - issue_cyc[0]), 64'd22);

        // Zero-window run.
        win_valid = 1'b1;
        run(0);
        wait_done("t4");
        chk("t4_done_lat", 64'(done_cyc - start_cyc), 64'd1);
        chk("t4_issues", 64'(iss_k), 64'd0);

        // start and cfg_num_win changes during RUN are ignored.
        run(3);
        repeat (2) @(posedge clk);
        #1;
        start       = 1'b1;
        cfg_num_win = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t5");
        chk("t5_issues", 64'(iss_k), 64'd12);
        chk("t5_pops", 64'(pop_p), 64'd12);
        chk("t5_last_idx", 64'(last_idx), 64'd11);

        // Irregular producer and consumer.
        run(6);
        snap = done_cnt;
        for (int i = 0; i < 600 && done_cnt == snap; i++) begin
            win_valid = 1'($urandom_range(0, 1));
            res_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        chk("t6_done_seen", 64'(done_cnt != snap), 64'd1);
        chk("t6_issues", 64'(iss_k), 64'd24);
        chk("t6_pops", 64'(pop_p), 64'd24);

        // Reset with operations in flight, then a stray CE return.
        win_valid = 1'b1;
        res_ready = 1'b0;
        run(5);
        for (int i = 0; i < 50 && iss_k < 3; i++) @(posedge clk);
        #1;
        chk("t7_inflight", 64'(iss_k >= 3), 64'd1);
        do_reset();
        chk_idle_outputs("t7_after_rst");
        win_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk); #1;
        inj = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("t7_err_sticky", 64'(err), 64'd1);
        do_reset();
        chk("t7_err_clear", 64'(err), 64'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
